cam_dvp_tx: RTL and testbench

//  DVP camera-sensor emulator: generates cmos_pclk/vsyn/href/data[7:0] exactly as an OV-type sensor

---
 rtl/cam_dvp_tx.sv | 216 +++++++++++++++++++++
 tb/tb_cam_dvp_tx.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/cam_dvp_tx.sv
// cam_dvp_tx: emulates an OV-style DVP camera sensor (RGB565, high byte first, 2 bytes per pixel).
// Build macro CAM_TX_LINE_STAMP_EN: column 0 of every active line carries {4'hA, line[11:0]}.
module cam_dvp_tx #(
  parameter int H_ACTIVE  = 1024,
  parameter int H_BLANK   = 256,
  parameter int V_ACTIVE  = 750,
  parameter int VSYNC_LEN = 4,
  parameter int V_BACK    = 16,
  parameter int V_FRONT   = 8
) (
  input  logic        clk_24M,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic [1:0]  pat_sel_i,
  input  logic [15:0] solid_i,
  output logic        cmos_pclk,
  output logic        cmos_vsyn,
  output logic        cmos_href,
  output logic [7:0]  cmos_data,
  output logic        frame_done,
  output logic [15:0] frame_cnt,
  output logic        busy
);

  localparam int LINE_LEN = 2 * H_ACTIVE + H_BLANK;
  localparam int POS_W    = $clog2(LINE_LEN);
  localparam int LMAX_A   = (VSYNC_LEN > V_BACK) ? VSYNC_LEN : V_BACK;
  localparam int LMAX_B   = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
  localparam int LMAX     = (LMAX_A > LMAX_B) ? LMAX_A : LMAX_B;
  localparam int LINE_W   = $clog2(LMAX + 1);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(LINE_LEN - 1);
  localparam logic [POS_W:0]   HREF_END = (POS_W + 1)'(2 * H_ACTIVE);

`ifdef CAM_TX_LINE_STAMP_EN
  localparam bit STAMP_EN = 1'b1;
`else
  localparam bit STAMP_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_VSYNC  = 3'd1,
    ST_VBACK  = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_VFRONT = 3'd4
  } state_t;

  state_t             state_r, nxt_state_s;
  logic [POS_W-1:0]   pos_r, nxt_pos_s;
  logic [LINE_W-1:0]  line_r, nxt_line_s;
  logic [1:0]         pat_r;
  logic [15:0]        solid_r;
  logic               frame_end_s, vsyn_rise_s, tick_s;
  logic               nxt_vsyn_s, nxt_href_s;
  logic [7:0]         nxt_data_s;
  logic [31:0]        col_s;
  logic [15:0]        pix_s;

  function automatic logic [LINE_W-1:0] last_line(input state_t st);
    case (st)
      ST_VSYNC:  return LINE_W'(VSYNC_LEN - 1);
      ST_VBACK:  return LINE_W'((V_BACK > 0) ? V_BACK - 1 : 0);
      ST_ACTIVE: return LINE_W'(V_ACTIVE - 1);
      ST_VFRONT: return LINE_W'((V_FRONT > 0) ? V_FRONT - 1 : 0);
      default:   return LINE_W'(0);
    endcase
  endfunction

  // Zero-length phases are skipped; ST_IDLE here marks the end of a frame
  function automatic state_t phase_after(input state_t st);
    case (st)
      ST_VSYNC:  return (V_BACK > 0) ? ST_VBACK : ST_ACTIVE;
      ST_VBACK:  return ST_ACTIVE;
      ST_ACTIVE: return (V_FRONT > 0) ? ST_VFRONT : ST_IDLE;
      ST_VFRONT: return ST_IDLE;
      default:   return ST_IDLE;
    endcase
  endfunction

  function automatic logic [15:0] bar_colour(input logic [2:0] bar);
    case (bar)
      3'd0:    return 16'hFFFF;
      3'd1:    return 16'hFFE0;
      3'd2:    return 16'h07FF;
      3'd3:    return 16'h07E0;
      3'd4:    return 16'hF81F;
      3'd5:    return 16'hF800;
      3'd6:    return 16'h001F;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic [15:0] pixel(input logic [1:0] pat, input logic [15:0] solid,
                                        input logic [31:0] col, input logic [11:0] row);
    if (STAMP_EN && (col == 32'd0)) begin
      return {4'hA, row};
    end else begin
      case (pat)
        2'd0:    return col[15:0];
        2'd1:    return bar_colour(3'((col * 32'd8) / 32'(H_ACTIVE)));
        2'd2:    return solid;
        2'd3:    return {row[7:0], col[7:0]};
        default: return 16'h0000;
      endcase
    end
  endfunction

  // Bus updates happen only on the edge where pclk falls
  assign tick_s = cmos_pclk;

  // Frame sequencer: advance position, line and phase by one pclk period
  always_comb begin
    nxt_state_s = state_r;
    nxt_pos_s   = pos_r;
    nxt_line_s  = line_r;
    frame_end_s = 1'b0;
    vsyn_rise_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (en_i) begin
          nxt_state_s = ST_VSYNC;
          nxt_pos_s   = '0;
          nxt_line_s  = '0;
          vsyn_rise_s = 1'b1;
        end else begin
          nxt_state_s = ST_IDLE;
        end
      end
      ST_VSYNC, ST_VBACK, ST_ACTIVE, ST_VFRONT: begin
        if (pos_r != POS_LAST) begin
          nxt_pos_s = pos_r + POS_W'(1);
        end else if (line_r != last_line(state_r)) begin
          nxt_pos_s  = '0;
          nxt_line_s = line_r + LINE_W'(1);
        end else begin
          nxt_pos_s   = '0;
          nxt_line_s  = '0;
          nxt_state_s = phase_after(state_r);
          if (nxt_state_s == ST_IDLE) begin
            frame_end_s = 1'b1;
            // en_i is only honoured here, so a frame in flight always completes
            if (en_i) begin
              nxt_state_s = ST_VSYNC;
              vsyn_rise_s = 1'b1;
            end else begin
              nxt_state_s = ST_IDLE;
            end
          end else begin
            frame_end_s = 1'b0;
          end
        end
      end
      default: begin
        nxt_state_s = ST_IDLE;
        nxt_pos_s   = '0;
        nxt_line_s  = '0;
      end
    endcase
  end

  // Bus values for the pclk period being entered
  always_comb begin
    col_s      = 32'(nxt_pos_s >> 1);
    pix_s      = pixel(pat_r, solid_r, col_s, 12'(nxt_line_s));
    nxt_vsyn_s = (nxt_state_s == ST_VSYNC);
    nxt_href_s = (nxt_state_s == ST_ACTIVE) && ({1'b0, nxt_pos_s} < HREF_END);
    if (nxt_href_s) begin
      nxt_data_s = nxt_pos_s[0] ? pix_s[7:0] : pix_s[15:8];
    end else begin
      nxt_data_s = 8'h00;
    end
  end

  // Pixel clock: free-running divide-by-two
  always_ff @(posedge clk_24M or posedge rst_i) begin
    if (rst_i) cmos_pclk <= 1'b0;
    else       cmos_pclk <= ~cmos_pclk;
  end

  // Sequencer state, DVP bus and frame bookkeeping
  always_ff @(posedge clk_24M or posedge rst_i) begin
    if (rst_i) begin
      state_r    <= ST_IDLE;
      pos_r      <= '0;
      line_r     <= '0;
      pat_r      <= 2'd0;
      solid_r    <= 16'h0000;
      cmos_vsyn  <= 1'b0;
      cmos_href  <= 1'b0;
      cmos_data  <= 8'h00;
      frame_done <= 1'b0;
      frame_cnt  <= 16'h0000;
      busy       <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (tick_s) begin
        state_r   <= nxt_state_s;
        pos_r     <= nxt_pos_s;
        line_r    <= nxt_line_s;
        cmos_vsyn <= nxt_vsyn_s;
        cmos_href <= nxt_href_s;
        cmos_data <= nxt_data_s;
        busy      <= (nxt_state_s != ST_IDLE);
        if (frame_end_s) begin
          frame_done <= 1'b1;
          frame_cnt  <= frame_cnt + 16'd1;
        end
        if (vsyn_rise_s) begin
          pat_r   <= pat_sel_i;
          solid_r <= solid_i;
        end
      end
    end
  end

endmodule

// File: tb/tb_cam_dvp_tx.sv
// Directed bench for cam_dvp_tx with small frame geometry (L = 14 pclk, frame = 84 pclk).
`timescale 1ns/1ps
module tb_cam_dvp_tx;

  logic        clk_24M = 1'b0;
  logic        rst_i;
  logic        en_i = 1'b1;
  logic [1:0]  pat_sel_i = 2'd0;
  logic [15:0] solid_i = 16'h0000;
  logic        cmos_pclk, cmos_vsyn, cmos_href, frame_done, busy;
  logic [7:0]  cmos_data;
  logic [15:0] frame_cnt;

  int checks = 0;
  int errors = 0;

`ifdef CAM_TX_LINE_STAMP_EN
  localparam bit STAMP = 1'b1;
`else
  localparam bit STAMP = 1'b0;
`endif

  localparam logic [63:0] PAT0_LINE = 64'h0000_0001_0002_0003;
  localparam logic [63:0] SOLID_LINE = 64'hF81F_F81F_F81F_F81F;

  cam_dvp_tx #(
    .H_ACTIVE(4), .H_BLANK(6), .V_ACTIVE(3), .VSYNC_LEN(1), .V_BACK(1), .V_FRONT(1)
  ) dut (
    .clk_24M(clk_24M), .rst_i(rst_i), .en_i(en_i), .pat_sel_i(pat_sel_i), .solid_i(solid_i),
    .cmos_pclk(cmos_pclk), .cmos_vsyn(cmos_vsyn), .cmos_href(cmos_href), .cmos_data(cmos_data),
    .frame_done(frame_done), .frame_cnt(frame_cnt), .busy(busy)
  );

  always #10 clk_24M = ~clk_24M;

  // Receiver-side capture: one sample per pclk period, taken while pclk is high
  logic [7:0] byte_q[$];
  int line_lens[$];
  int vs_lens[$];
  int vs_rise[$];
  int slot = 0, toggles = 0, done_cnt = 0, vs_run = 0, h_run = 0;
  logic pclk_prev = 1'b0, vsyn_prev = 1'b0;

  initial begin
    forever begin
      @(negedge clk_24M);
      if (cmos_pclk !== pclk_prev) toggles++;
      pclk_prev = cmos_pclk;
      if (frame_done === 1'b1) done_cnt++;
      if (cmos_pclk === 1'b1) begin
        if (cmos_vsyn === 1'b1 && vsyn_prev !== 1'b1) vs_rise.push_back(slot);
        if (cmos_vsyn === 1'b1) vs_run++;
        else if (vs_run > 0) begin vs_lens.push_back(vs_run); vs_run = 0; end
        if (cmos_href === 1'b1) begin byte_q.push_back(cmos_data); h_run++; end
        else if (h_run > 0) begin line_lens.push_back(h_run); h_run = 0; end
        vsyn_prev = cmos_vsyn;
        slot++;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] line_bytes(input int base);
    logic [63:0] v = '0;
    for (int i = 0; i < 8; i++) begin
      v = {v[55:0], (base + i < byte_q.size()) ? byte_q[base + i] : 8'hxx};
    end
    return v;
  endfunction

  function automatic logic [63:0] stamped(input logic [63:0] v, input logic [7:0] row);
    return STAMP ? {8'hA0, row, v[47:0]} : v;
  endfunction

  function automatic int lens_at(input int i);
    return (i < line_lens.size()) ? line_lens[i] : -1;
  endfunction

  function automatic int vs_at(input int i);
    return (i < vs_lens.size()) ? vs_lens[i] : -1;
  endfunction

  task automatic wait_done(input int n, input string tag);
    int k = 0;
    while (done_cnt < n && k < 3000) begin @(negedge clk_24M); #1; k++; end
    check(tag, 64'(done_cnt >= n), 64'd1);
  endtask

  task automatic wait_lines(input int n, input string tag);
    int k = 0;
    while (line_lens.size() < n && k < 3000) begin @(negedge clk_24M); #1; k++; end
    check(tag, 64'(line_lens.size() >= n), 64'd1);
  endtask

  task automatic wait_href(input string tag);
    int k = 0;
    while (cmos_href !== 1'b1 && k < 3000) begin @(negedge clk_24M); #1; k++; end
    check(tag, 64'(cmos_href), 64'd1);
  endtask

  task automatic check_frame(input string tag, input int bbase, input int lbase,
                             input logic [63:0] l0, input logic [63:0] l1, input logic [63:0] l2);
    check({tag, "_len0"}, 64'(lens_at(lbase)),     64'd8);
    check({tag, "_len1"}, 64'(lens_at(lbase + 1)), 64'd8);
    check({tag, "_len2"}, 64'(lens_at(lbase + 2)), 64'd8);
    check({tag, "_line0"}, line_bytes(bbase),      stamped(l0, 8'd0));
    check({tag, "_line1"}, line_bytes(bbase + 8),  stamped(l1, 8'd1));
    check({tag, "_line2"}, line_bytes(bbase + 16), stamped(l2, 8'd2));
  endtask

  initial begin
    int t0, bb, lb, vb, dstart;
    rst_i = 1'b0;
    #1 rst_i = 1'b1;

    // 1: reset holds everything at 0, pclk frozen
    repeat (5) @(posedge clk_24M);
    #1;
    check("rst_pclk", 64'(cmos_pclk), 64'd0);
    check("rst_vsyn", 64'(cmos_vsyn), 64'd0);
    check("rst_href", 64'(cmos_href), 64'd0);
    check("rst_data", 64'(cmos_data), 64'd0);
    check("rst_done", 64'(frame_done), 64'd0);
    check("rst_cnt",  64'(frame_cnt), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_no_toggle", 64'(toggles), 64'd0);
    @(negedge clk_24M); #1;
    rst_i = 1'b0;
    t0 = toggles;
    repeat (8) @(negedge clk_24M);
    #1;
    check("pclk_toggles", 64'(toggles - t0), 64'd8);
    check("vsyn_up", 64'(cmos_vsyn), 64'd1);
    check("busy_up", 64'(busy), 64'd1);

    // 2: first frame, pattern 0
    wait_done(1, "wait_f1");
    check("f1_done_pulse", 64'(frame_done), 64'd1);
    check("f1_cnt", 64'(frame_cnt), 64'd1);
    check("f1_done_cnt", 64'(done_cnt), 64'd1);
    check("f1_vsyn_len", 64'(vs_at(0)), 64'd14);
    check_frame("f1", 0, 0, PAT0_LINE, PAT0_LINE, PAT0_LINE);
    @(negedge clk_24M); #1;
    check("f1_done_1clk", 64'(frame_done), 64'd0);
    check("f1_busy_cont", 64'(busy), 64'd1);
    repeat (6) @(negedge clk_24M); #1;
    check("frame_period", 64'((vs_rise.size() >= 2) ? vs_rise[1] - vs_rise[0] : -1), 64'd84);

    // 5: pattern change in ACTIVE is deferred to the next frame
    wait_lines(4, "wait_f2_l0");
    pat_sel_i = 2'd2;
    solid_i = 16'hF81F;
    wait_done(2, "wait_f2");
    check("f2_cnt", 64'(frame_cnt), 64'd2);
    check("f2_line1_pat0", line_bytes(32), stamped(PAT0_LINE, 8'd1));
    check("f2_line2_pat0", line_bytes(40), stamped(PAT0_LINE, 8'd2));
    pat_sel_i = 2'd3;
    wait_done(3, "wait_f3");
    check_frame("f3_solid", 48, 6, SOLID_LINE, SOLID_LINE, SOLID_LINE);

    // 3 + 4: pattern 3 frame, en_i dropped during line 1
    wait_lines(10, "wait_f4_l0");
    wait_href("wait_f4_l1");
    en_i = 1'b0;
    wait_done(4, "wait_f4");
    check("f4_cnt", 64'(frame_cnt), 64'd4);
    check("f4_busy_fall", 64'(busy), 64'd0);
    check_frame("f4_pat3", 72, 9, 64'h0000_0001_0002_0003,
                64'h0100_0101_0102_0103, 64'h0200_0201_0202_0203);
    repeat (300) @(negedge clk_24M); #1;
    check("idle_vsyn", 64'(cmos_vsyn), 64'd0);
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_no_rise", 64'(vs_rise.size()), 64'd4);
    check("idle_done_cnt", 64'(done_cnt), 64'd4);
    check("idle_cnt", 64'(frame_cnt), 64'd4);

    // 6: reset mid-href, then a clean frame
    en_i = 1'b1;
    wait_lines(13, "wait_f5_l0");
    wait_href("wait_f5_l1");
    repeat (2) @(negedge clk_24M);
    #3;
    check("pre_rst_href", 64'(cmos_href), 64'd1);
    rst_i = 1'b1;
    #1;
    check("mid_rst_href", 64'(cmos_href), 64'd0);
    check("mid_rst_data", 64'(cmos_data), 64'd0);
    check("mid_rst_pclk", 64'(cmos_pclk), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_cnt",  64'(frame_cnt), 64'd0);
    pat_sel_i = 2'd0;
    repeat (3) @(negedge clk_24M);
    #1 rst_i = 1'b0;
    repeat (10) @(negedge clk_24M); #1;
    bb = byte_q.size();
    lb = line_lens.size();
    vb = vs_lens.size();
    dstart = done_cnt;
    wait_done(dstart + 1, "wait_f6");
    check("f6_cnt", 64'(frame_cnt), 64'd1);
    check("f6_vsyn_len", 64'(vs_at(vb)), 64'd14);
    check_frame("f6", bb, lb, PAT0_LINE, PAT0_LINE, PAT0_LINE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
